ccode_unit: RTL and testbench

//  Banked condition-code register plus pipelined branch-condition evaluator with valid/ready handshake.

---
 rtl/ccode_if.sv | 37 +++
 rtl/ccode_unit.sv | 111 +++++++++++
 tb/tb_ccode_unit.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ccode_if.sv
// Flag-write, request and response signals shared by ccode_unit and its neighbours.
// The master is the sequencer/ALU side; the slave is the condition-code unit.
interface ccode_if #(
   parameter int NUM_BANKS = 4
);
   localparam int BW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

   logic [2:0]    flag_we;
   logic [BW-1:0] flag_bank;
   logic [2:0]    flag_in;

   logic          req_valid;
   logic          req_ready;
   logic          req_branch;
   logic [2:0]    req_cond;
   logic [BW-1:0] req_bank;

   logic          rsp_valid;
   logic          rsp_ready;
   logic          rsp_cond_true;

   modport master (
      output flag_we, flag_bank, flag_in,
      output req_valid, req_branch, req_cond, req_bank,
      input  req_ready,
      input  rsp_valid, rsp_cond_true,
      output rsp_ready
   );

   modport slave (
      input  flag_we, flag_bank, flag_in,
      input  req_valid, req_branch, req_cond, req_bank,
      output req_ready,
      output rsp_valid, rsp_cond_true,
      input  rsp_ready
   );
endinterface

// File: rtl/ccode_unit.sv
// Banked NVZ condition-code register with a one-stage branch-condition evaluator.
// Each accepted request yields one registered cond_true result; saturating
// counters track how many branches were evaluated and how many were taken.
module ccode_unit #(
   parameter int NUM_BANKS = 4,
   parameter bit BYPASS    = 1'b1,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   ccode_if.slave           bus,
   input  logic             cnt_clr,
   output logic [CNT_W-1:0] eval_cnt,
   output logic [CNT_W-1:0] taken_cnt
);
   localparam int            BW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
   localparam logic [BW:0]   NB = (BW+1)'(NUM_BANKS);

   // Flags are {N,V,Z}; the condition table is indexed by the 3-bit code.
   function automatic logic cond_eval(input logic [2:0] c, input logic [2:0] nvz);
      logic n, v, z;
      n = nvz[2];
      v = nvz[1];
      z = nvz[0];
      case (c)
         3'd0:    cond_eval = ~z;
         3'd1:    cond_eval = z;
         3'd2:    cond_eval = ~z & ~n;
         3'd3:    cond_eval = n;
         3'd4:    cond_eval = z | ~n;
         3'd5:    cond_eval = n | z;
         3'd6:    cond_eval = v;
         default: cond_eval = 1'b1;
      endcase
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
      return (&x) ? x : x + 1'b1;
   endfunction

   logic [2:0] bank_flags [NUM_BANKS];

   logic       wr_ok_p0;
   logic       rd_ok_p0;
   logic [2:0] stored_p0;
   logic [2:0] eff_p0;
   logic       result_p0;
   logic       accept_p0;

   logic       vld_p1;
   logic       cond_p1;

   // Stage p0: bank lookup, optional same-cycle write bypass, condition evaluation, handshake
   always_comb begin
      wr_ok_p0  = ({1'b0, bus.flag_bank} < NB);
      rd_ok_p0  = ({1'b0, bus.req_bank} < NB);
      stored_p0 = rd_ok_p0 ? bank_flags[bus.req_bank] : 3'b000;
      eff_p0    = stored_p0;
      for (int i = 0; i < 3; i++) begin
         if (BYPASS && wr_ok_p0 && bus.flag_we[i] && (bus.flag_bank == bus.req_bank))
            eff_p0[i] = bus.flag_in[i];
      end
      result_p0 = bus.req_branch & cond_eval(bus.req_cond, eff_p0);
      accept_p0 = bus.req_valid & bus.req_ready;
   end

   assign bus.req_ready     = ~vld_p1 | bus.rsp_ready;
   assign bus.rsp_valid     = vld_p1;
   assign bus.rsp_cond_true = cond_p1;

   // Masked per-bit flag writes; out-of-range banks are silently dropped
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int b = 0; b < NUM_BANKS; b++) bank_flags[b] <= 3'b000;
      end else begin
         for (int b = 0; b < NUM_BANKS; b++) begin
            for (int i = 0; i < 3; i++) begin
               if (wr_ok_p0 && (bus.flag_bank == BW'(b)) && bus.flag_we[i])
                  bank_flags[b][i] <= bus.flag_in[i];
            end
         end
      end
   end

   // Stage p1: response register; result captured at accept and held through stalls
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1  <= 1'b0;
         cond_p1 <= 1'b0;
      end else if (accept_p0) begin
         vld_p1  <= 1'b1;
         cond_p1 <= result_p0;
      end else if (bus.rsp_ready) begin
         vld_p1  <= 1'b0;
      end
   end

   // Saturating branch statistics; clear takes priority over a same-cycle increment
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         eval_cnt  <= '0;
         taken_cnt <= '0;
      end else if (cnt_clr) begin
         eval_cnt  <= '0;
         taken_cnt <= '0;
      end else if (accept_p0 && bus.req_branch) begin
         eval_cnt <= sat_inc(eval_cnt);
         if (result_p0) taken_cnt <= sat_inc(taken_cnt);
      end
   end
endmodule

// File: tb/tb_ccode_unit.sv
// Bench for ccode_unit: a bypassing instance and a non-bypassing instance share
// one stimulus stream and are compared against a transaction-level model.
module tb_ccode_unit;
   logic       clk;
   logic       rst_n;
   logic       cnt_clr;
   logic [3:0] eval0, taken0, eval1, taken1;

   ccode_if #(.NUM_BANKS(4)) b0 ();
   ccode_if #(.NUM_BANKS(4)) b1 ();

   assign b1.flag_we    = b0.flag_we;
   assign b1.flag_bank  = b0.flag_bank;
   assign b1.flag_in    = b0.flag_in;
   assign b1.req_valid  = b0.req_valid;
   assign b1.req_branch = b0.req_branch;
   assign b1.req_cond   = b0.req_cond;
   assign b1.req_bank   = b0.req_bank;
   assign b1.rsp_ready  = b0.rsp_ready;

   ccode_unit #(.NUM_BANKS(4), .BYPASS(1'b1), .CNT_W(4)) u_byp (
      .clk(clk), .rst_n(rst_n), .bus(b0.slave), .cnt_clr(cnt_clr),
      .eval_cnt(eval0), .taken_cnt(taken0));

   ccode_unit #(.NUM_BANKS(4), .BYPASS(1'b0), .CNT_W(4)) u_nobyp (
      .clk(clk), .rst_n(rst_n), .bus(b1.slave), .cnt_clr(cnt_clr),
      .eval_cnt(eval1), .taken_cnt(taken1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_pass = 0;
   int n_total = 0;

   // Reference model state
   bit [2:0] m_flags [4];
   bit       m_vld;
   bit       m_val0, m_val1;
   int       m_eval, m_taken0, m_taken1;

   function automatic bit m_cond(int c, bit [2:0] f);
      bit n, v, z;
      n = f[2]; v = f[1]; z = f[0];
      case (c)
         0: return !z;
         1: return z;
         2: return !z && !n;
         3: return n;
         4: return z || !n;
         5: return n || z;
         6: return v;
         default: return 1'b1;
      endcase
   endfunction

   function automatic bit m_result(bit bypass);
      bit [2:0] f;
      int rb, wb;
      if (!b0.req_branch) return 1'b0;
      rb = int'(b0.req_bank);
      wb = int'(b0.flag_bank);
      f  = (rb < 4) ? m_flags[rb] : 3'b000;
      if (bypass && rb == wb && wb < 4)
         for (int i = 0; i < 3; i++) if (b0.flag_we[i]) f[i] = b0.flag_in[i];
      return m_cond(int'(b0.req_cond), f);
   endfunction

   task automatic model_reset();
      for (int b = 0; b < 4; b++) m_flags[b] = 3'b000;
      m_vld = 0; m_val0 = 0; m_val1 = 0;
      m_eval = 0; m_taken0 = 0; m_taken1 = 0;
   endtask

   task automatic idle();
      b0.flag_we = 3'b000; b0.flag_bank = 2'd0; b0.flag_in = 3'b000;
      b0.req_valid = 1'b0; b0.req_branch = 1'b0; b0.req_cond = 3'd0; b0.req_bank = 2'd0;
      b0.rsp_ready = 1'b1; cnt_clr = 1'b0;
   endtask

   // Advance one clock: update the model from the currently driven inputs
   task automatic step();
      bit acc, r0, r1;
      int wb;
      acc = b0.req_valid && (!m_vld || b0.rsp_ready);
      r0  = m_result(1'b1);
      r1  = m_result(1'b0);
      if (acc) begin
         m_vld = 1; m_val0 = r0; m_val1 = r1;
      end else if (b0.rsp_ready) begin
         m_vld = 0;
      end
      if (cnt_clr) begin
         m_eval = 0; m_taken0 = 0; m_taken1 = 0;
      end else if (acc && b0.req_branch) begin
         if (m_eval < 15) m_eval++;
         if (r0 && m_taken0 < 15) m_taken0++;
         if (r1 && m_taken1 < 15) m_taken1++;
      end
      wb = int'(b0.flag_bank);
      if (wb < 4)
         for (int i = 0; i < 3; i++) if (b0.flag_we[i]) m_flags[wb][i] = b0.flag_in[i];
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle();
      b0.req_valid = 1; b0.req_branch = 1; b0.req_cond = 3'd7;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      n_total++; if (b0.rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got=%b exp=0", b0.rsp_valid); else n_pass++;
      n_total++; if (b0.rsp_cond_true !== 1'b0) $display("FAIL reset_cond got=%b exp=0", b0.rsp_cond_true); else n_pass++;
      n_total++; if (eval0 !== 4'd0 || taken0 !== 4'd0) $display("FAIL reset_cnt got=%0d/%0d exp=0/0", eval0, taken0); else n_pass++;
      n_total++; if (b1.rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid_nb got=%b exp=0", b1.rsp_valid); else n_pass++;
      idle();
      @(negedge clk);
      rst_n = 1'b1;
      step();
      b0.req_valid = 1; b0.req_branch = 1; b0.req_bank = 2'd0; b0.req_cond = 3'd0;
      step();
      n_total++; if (b0.rsp_valid !== 1'b1) $display("FAIL first_rsp_valid got=%b exp=1", b0.rsp_valid); else n_pass++;
      n_total++; if (b0.rsp_cond_true !== 1'b1) $display("FAIL first_ne got=%b exp=1", b0.rsp_cond_true); else n_pass++;
      b0.req_cond = 3'd1;
      step();
      n_total++; if (b0.rsp_cond_true !== 1'b0) $display("FAIL first_eq got=%b exp=0", b0.rsp_cond_true); else n_pass++;
      idle();
      step();
   endtask

   task automatic test_cond_table();
      bit exp_tab [8] = '{1, 0, 0, 1, 0, 1, 0, 1};
      b0.flag_we = 3'b111; b0.flag_bank = 2'd2; b0.flag_in = 3'b100;
      step();
      idle();
      for (int c = 0; c < 8; c++) begin
         b0.req_valid = 1; b0.req_branch = 1; b0.req_bank = 2'd2; b0.req_cond = 3'(c);
         step();
         n_total++;
         if (b0.rsp_valid !== 1'b1 || b0.rsp_cond_true !== exp_tab[c])
            $display("FAIL cond_c%0d got=%b/%b exp=1/%b", c, b0.rsp_valid, b0.rsp_cond_true, exp_tab[c]);
         else n_pass++;
      end
      b0.req_bank = 2'd1; b0.req_cond = 3'd1;
      step();
      n_total++; if (b0.rsp_cond_true !== 1'b0) $display("FAIL bank1_untouched got=%b exp=0", b0.rsp_cond_true); else n_pass++;
      idle();
      step();
   endtask

   task automatic test_bypass();
      b0.flag_we = 3'b001; b0.flag_bank = 2'd1; b0.flag_in = 3'b001;
      b0.req_valid = 1; b0.req_branch = 1; b0.req_bank = 2'd1; b0.req_cond = 3'd1;
      step();
      n_total++; if (b0.rsp_cond_true !== 1'b1) $display("FAIL bypass_on got=%b exp=1", b0.rsp_cond_true); else n_pass++;
      n_total++; if (b1.rsp_cond_true !== 1'b0) $display("FAIL bypass_off got=%b exp=0", b1.rsp_cond_true); else n_pass++;
      b0.flag_we = 3'b000;
      step();
      n_total++; if (b0.rsp_cond_true !== 1'b1 || b1.rsp_cond_true !== 1'b1)
         $display("FAIL after_write got=%b/%b exp=1/1", b0.rsp_cond_true, b1.rsp_cond_true); else n_pass++;
      idle();
      b0.flag_we = 3'b010; b0.flag_bank = 2'd1; b0.flag_in = 3'b111;
      step();
      idle();
      b0.req_valid = 1; b0.req_branch = 1; b0.req_bank = 2'd1; b0.req_cond = 3'd6;
      step();
      n_total++; if (b0.rsp_cond_true !== 1'b1) $display("FAIL masked_ov got=%b exp=1", b0.rsp_cond_true); else n_pass++;
      b0.req_cond = 3'd1;
      step();
      n_total++; if (b0.rsp_cond_true !== 1'b1) $display("FAIL masked_z_hold got=%b exp=1", b0.rsp_cond_true); else n_pass++;
      b0.req_cond = 3'd3;
      step();
      n_total++; if (b0.rsp_cond_true !== 1'b0) $display("FAIL masked_n_hold got=%b exp=0", b0.rsp_cond_true); else n_pass++;
      idle();
      step();
   endtask

   task automatic test_stall();
      bit got[$];
      bit exp_seq [3] = '{1, 1, 0};
      // A: bank0 ne with Z=0
      b0.req_valid = 1; b0.req_branch = 1; b0.req_bank = 2'd0; b0.req_cond = 3'd0;
      step();
      // B pending: bank0 eq; consumer stalls; bank0 Z is set during the stall
      b0.req_cond = 3'd1; b0.rsp_ready = 0;
      b0.flag_we = 3'b001; b0.flag_bank = 2'd0; b0.flag_in = 3'b001;
      #1;
      n_total++; if (b0.req_ready !== 1'b0) $display("FAIL stall_ready got=%b exp=0", b0.req_ready); else n_pass++;
      for (int k = 0; k < 4; k++) begin
         step();
         b0.flag_we = 3'b000;
         n_total++;
         if (b0.rsp_valid !== 1'b1 || b0.rsp_cond_true !== 1'b1 || b0.req_ready !== 1'b0)
            $display("FAIL stall_hold%0d got=%b/%b/%b exp=1/1/0", k, b0.rsp_valid, b0.rsp_cond_true, b0.req_ready);
         else n_pass++;
      end
      b0.rsp_ready = 1;
      for (int k = 0; k < 4; k++) begin
         if (b0.rsp_valid && b0.rsp_ready) got.push_back(b0.rsp_cond_true);
         step();
         if (k == 0) b0.req_cond = 3'd0;
         if (k == 1) b0.req_valid = 0;
      end
      n_total++; if (got.size() != 3) $display("FAIL stall_count got=%0d exp=3", got.size()); else n_pass++;
      for (int k = 0; k < 3 && k < got.size(); k++) begin
         n_total++;
         if (got[k] !== exp_seq[k]) $display("FAIL stall_order%0d got=%b exp=%b", k, got[k], exp_seq[k]);
         else n_pass++;
      end
      idle();
      step();
   endtask

   task automatic test_counters();
      cnt_clr = 1;
      step();
      cnt_clr = 0;
      n_total++; if (eval0 !== 4'd0 || taken0 !== 4'd0) $display("FAIL clr got=%0d/%0d exp=0/0", eval0, taken0); else n_pass++;
      b0.req_valid = 1; b0.req_branch = 1; b0.req_bank = 2'd2; b0.req_cond = 3'd7;
      repeat (20) step();
      n_total++; if (eval0 !== 4'd15 || taken0 !== 4'd15) $display("FAIL sat got=%0d/%0d exp=15/15", eval0, taken0); else n_pass++;
      n_total++; if (eval1 !== 4'd15 || taken1 !== 4'd15) $display("FAIL sat_nb got=%0d/%0d exp=15/15", eval1, taken1); else n_pass++;
      cnt_clr = 1;
      step();
      cnt_clr = 0;
      n_total++; if (eval0 !== 4'd0 || taken0 !== 4'd0) $display("FAIL clr_wins got=%0d/%0d exp=0/0", eval0, taken0); else n_pass++;
      b0.req_branch = 0;
      repeat (3) step();
      n_total++; if (eval0 !== 4'd0 || taken0 !== 4'd0) $display("FAIL nobranch got=%0d/%0d exp=0/0", eval0, taken0); else n_pass++;
      n_total++; if (b0.rsp_cond_true !== 1'b0) $display("FAIL nobranch_res got=%b exp=0", b0.rsp_cond_true); else n_pass++;
      b0.req_branch = 1;
      step();
      b0.req_cond = 3'd1;
      step();
      n_total++; if (eval0 !== 4'd2 || taken0 !== 4'd1) $display("FAIL cnt_mix got=%0d/%0d exp=2/1", eval0, taken0); else n_pass++;
      idle();
      step();
   endtask

   task automatic test_random();
      for (int n = 0; n < 300; n++) begin
         b0.flag_we    = 3'($urandom_range(0, 7));
         b0.flag_bank  = 2'($urandom_range(0, 3));
         b0.flag_in    = 3'($urandom_range(0, 7));
         b0.req_valid  = ($urandom_range(0, 3) != 0);
         b0.req_branch = ($urandom_range(0, 4) != 0);
         b0.req_cond   = 3'($urandom_range(0, 7));
         b0.req_bank   = ($urandom_range(0, 1) != 0) ? b0.flag_bank : 2'($urandom_range(0, 3));
         b0.rsp_ready  = ($urandom_range(0, 9) < 7);
         cnt_clr       = ($urandom_range(0, 49) == 0);
         #1;
         n_total++;
         if (b0.req_ready !== (!m_vld || b0.rsp_ready))
            $display("FAIL rnd_ready n=%0d got=%b exp=%b", n, b0.req_ready, (!m_vld || b0.rsp_ready));
         else n_pass++;
         step();
         n_total++;
         if (b0.rsp_valid !== m_vld || b0.rsp_cond_true !== m_val0)
            $display("FAIL rnd_rsp n=%0d got=%b/%b exp=%b/%b", n, b0.rsp_valid, b0.rsp_cond_true, m_vld, m_val0);
         else n_pass++;
         n_total++;
         if (b1.rsp_valid !== m_vld || b1.rsp_cond_true !== m_val1)
            $display("FAIL rnd_rsp_nb n=%0d got=%b/%b exp=%b/%b", n, b1.rsp_valid, b1.rsp_cond_true, m_vld, m_val1);
         else n_pass++;
         n_total++;
         if (eval0 !== 4'(m_eval) || taken0 !== 4'(m_taken0) || eval1 !== 4'(m_eval) || taken1 !== 4'(m_taken1))
            $display("FAIL rnd_cnt n=%0d got=%0d/%0d/%0d/%0d exp=%0d/%0d/%0d/%0d", n,
                     eval0, taken0, eval1, taken1, m_eval, m_taken0, m_eval, m_taken1);
         else n_pass++;
      end
      idle();
      step();
   endtask

   task automatic test_reset_mid();
      b0.flag_we = 3'b111; b0.flag_bank = 2'd2; b0.flag_in = 3'b100;
      b0.req_valid = 1; b0.req_branch = 1; b0.req_bank = 2'd3; b0.req_cond = 3'd7;
      step();
      idle();
      b0.rsp_ready = 0;
      step();
      n_total++; if (b0.rsp_valid !== 1'b1 || eval0 === 4'd0) $display("FAIL pre_reset got=%b/%0d exp=1/nonzero", b0.rsp_valid, eval0); else n_pass++;
      rst_n = 1'b0;
      model_reset();
      #2;
      n_total++; if (b0.rsp_valid !== 1'b0 || b0.rsp_cond_true !== 1'b0) $display("FAIL async_rst got=%b/%b exp=0/0", b0.rsp_valid, b0.rsp_cond_true); else n_pass++;
      n_total++; if (eval0 !== 4'd0 || taken0 !== 4'd0) $display("FAIL async_rst_cnt got=%0d/%0d exp=0/0", eval0, taken0); else n_pass++;
      idle();
      @(negedge clk);
      rst_n = 1'b1;
      step();
      b0.req_valid = 1; b0.req_branch = 1; b0.req_bank = 2'd2; b0.req_cond = 3'd3;
      step();
      n_total++; if (b0.rsp_cond_true !== 1'b0) $display("FAIL post_rst_n got=%b exp=0", b0.rsp_cond_true); else n_pass++;
      b0.req_cond = 3'd0;
      step();
      n_total++; if (b0.rsp_cond_true !== 1'b1) $display("FAIL post_rst_z got=%b exp=1", b0.rsp_cond_true); else n_pass++;
      idle();
      step();
   endtask

   initial begin
      test_reset();
      test_cond_table();
      test_bypass();
      test_stall();
      test_counters();
      test_random();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
